// File: rtl/face_color_sampler.sv
// rtl/face_color_sampler.sv - samples 4x4 RGB windows around nine cube centres over one frame and classifies sticker colours
module face_color_sampler (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [10:0] Block1X,
    input  logic [10:0] Block1Y,
    input  logic [10:0] Block2X,
    input  logic [10:0] Block2Y,
    input  logic [10:0] Block3X,
    input  logic [10:0] Block3Y,
    input  logic [10:0] Block4X,
    input  logic [10:0] Block4Y,
    input  logic [10:0] Block5X,
    input  logic [10:0] Block5Y,
    input  logic [10:0] Block6X,
    input  logic [10:0] Block6Y,
    input  logic [10:0] Block7X,
    input  logic [10:0] Block7Y,
    input  logic [10:0] Block8X,
    input  logic [10:0] Block8Y,
    input  logic [10:0] Block9X,
    input  logic [10:0] Block9Y,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [9:0]  pix_r,
    input  logic [9:0]  pix_g,
    input  logic [9:0]  pix_b,
    output logic        busy,
    output logic        done,
    output logic [26:0] face_colors
);

    typedef enum logic [2:0] {IDLE, WAIT_FRAME, CAPTURE, CLASSIFY, DONE} state_t;

    state_t      state, state_next;
    logic [10:0] in_x [9];
    logic [10:0] in_y [9];
    logic [10:0] cx [9];
    logic [10:0] cy [9];
    logic [13:0] sum_r [9];
    logic [13:0] sum_g [9];
    logic [13:0] sum_b [9];
    logic [4:0]  cnt [9];
    logic [3:0]  blk;
    logic [8:0]  hit;
    logic        acc_en;
    logic [9:0]  avg_r, avg_g, avg_b;
    logic [4:0]  sel_cnt;
    logic [2:0]  code;

    // Signed 12-bit compare so a centre near 0 clips the window instead of wrapping.
    function automatic logic in_window(input logic [10:0] c, input logic [10:0] p);
        logic signed [11:0] cs, ps;
        cs = $signed({1'b0, c});
        ps = $signed({1'b0, p});
        return (ps >= cs - 12'sd2) && (ps <= cs + 12'sd1);
    endfunction

    function automatic logic [2:0] classify(input logic [9:0] r, input logic [9:0] g,
                                            input logic [9:0] b, input logic [4:0] n);
        logic [2:0] c;
        if (n != 5'd16)                                       c = 3'd7;
        else if (r >= 10'd600 && g >= 10'd600 && b >= 10'd600) c = 3'd0;
        else if (r >= 10'd512 && g >= 10'd512 && b < 10'd384)  c = 3'd1;
        else if (r >= 10'd512 && g < 10'd256)                  c = 3'd2;
        else if (r >= 10'd512 && g < 10'd512)                  c = 3'd3;
        else if (g > r && g >= b)                              c = 3'd4;
        else                                                   c = 3'd5;
        return c;
    endfunction

    always_comb begin
        in_x[0] = Block1X; in_y[0] = Block1Y;
        in_x[1] = Block2X; in_y[1] = Block2Y;
        in_x[2] = Block3X; in_y[2] = Block3Y;
        in_x[3] = Block4X; in_y[3] = Block4Y;
        in_x[4] = Block5X; in_y[4] = Block5Y;
        in_x[5] = Block6X; in_y[5] = Block6Y;
        in_x[6] = Block7X; in_y[6] = Block7Y;
        in_x[7] = Block8X; in_y[7] = Block8Y;
        in_x[8] = Block9X; in_y[8] = Block9Y;
    end

    always_comb begin
        acc_en  = pix_valid && ((state == WAIT_FRAME && frame_start) ||
                                (state == CAPTURE && !frame_start));
        avg_r   = '0;
        avg_g   = '0;
        avg_b   = '0;
        sel_cnt = '0;
        for (int k = 0; k < 9; k++) begin
            hit[k] = in_window(cx[k], pix_x) && in_window(cy[k], pix_y);
            if (blk == 4'(k)) begin
                avg_r   = sum_r[k][13:4];
                avg_g   = sum_g[k][13:4];
                avg_b   = sum_b[k][13:4];
                sel_cnt = cnt[k];
            end
        end
        code = classify(avg_r, avg_g, avg_b, sel_cnt);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start)       state_next = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_next = CAPTURE;
            CAPTURE:    if (frame_start) state_next = CLASSIFY;
            CLASSIFY:   if (blk == 4'd8) state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            blk         <= '0;
            face_colors <= '1;
            for (int k = 0; k < 9; k++) begin
                cx[k]    <= '0;
                cy[k]    <= '0;
                sum_r[k] <= '0;
                sum_g[k] <= '0;
                sum_b[k] <= '0;
                cnt[k]   <= '0;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                for (int k = 0; k < 9; k++) begin
                    cx[k]    <= in_x[k];
                    cy[k]    <= in_y[k];
                    sum_r[k] <= '0;
                    sum_g[k] <= '0;
                    sum_b[k] <= '0;
                    cnt[k]   <= '0;
                end
            end else if (acc_en) begin
                // A full count blocks further adds, which is what keeps the sums within 14 bits.
                for (int k = 0; k < 9; k++) begin
                    if (hit[k] && cnt[k] != 5'd16) begin
                        sum_r[k] <= sum_r[k] + 14'(pix_r);
                        sum_g[k] <= sum_g[k] + 14'(pix_g);
                        sum_b[k] <= sum_b[k] + 14'(pix_b);
                        cnt[k]   <= cnt[k] + 5'd1;
                    end
                end
            end
            if (state == CAPTURE)
                blk <= '0;
            if (state == CLASSIFY) begin
                for (int k = 0; k < 9; k++)
                    if (blk == 4'(k))
                        face_colors[3*k +: 3] <= code;
                blk <= blk + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_face_color_sampler.sv
// tb/tb_face_color_sampler.sv - self-checking bench for face_color_sampler
module tb_face_color_sampler;

    logic        clk = 1'b0;
    logic        reset, start, frame_start, pix_valid;
    logic [10:0] bx [9];
    logic [10:0] by [9];
    logic [10:0] pix_x, pix_y;
    logic [9:0]  pix_r, pix_g, pix_b;
    logic        busy, done;
    logic [26:0] face_colors;

    always #5 clk = ~clk;

    face_color_sampler dut (
        .Clk(clk), .Reset(reset), .start(start),
        .Block1X(bx[0]), .Block1Y(by[0]), .Block2X(bx[1]), .Block2Y(by[1]),
        .Block3X(bx[2]), .Block3Y(by[2]), .Block4X(bx[3]), .Block4Y(by[3]),
        .Block5X(bx[4]), .Block5Y(by[4]), .Block6X(bx[5]), .Block6Y(by[5]),
        .Block7X(bx[6]), .Block7Y(by[6]), .Block8X(bx[7]), .Block8Y(by[7]),
        .Block9X(bx[8]), .Block9Y(by[8]),
        .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .busy(busy), .done(done), .face_colors(face_colors)
    );

    typedef struct {int v; int x; int y; int r; int g; int b;} pix_t;
    typedef struct {int r; int g; int b; int code;} vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t q[$];
    int   mcx [9], mcy [9], msr [9], msg [9], msb [9], mcnt [9];
    int   close_x, close_y;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pix_t mk(input int v, input int x, input int y, input int r, input int g, input int b);
        pix_t p;
        p.v = v; p.x = x; p.y = y; p.r = r; p.g = g; p.b = b;
        return p;
    endfunction

    function automatic int clip(input int c);
        return (c > 1023) ? 1023 : c;
    endfunction

    // Reference model: per-window sums straight from the window and saturation rules.
    task automatic model_pix(input pix_t p);
        for (int k = 0; k < 9; k++)
            if (p.x >= mcx[k] - 2 && p.x <= mcx[k] + 1 && p.y >= mcy[k] - 2 && p.y <= mcy[k] + 1
                && mcnt[k] < 16) begin
                msr[k] += p.r; msg[k] += p.g; msb[k] += p.b; mcnt[k]++;
            end
    endtask

    function automatic int mcode(input int k);
        int r, g, b;
        if (mcnt[k] != 16) return 7;
        r = msr[k] / 16; g = msg[k] / 16; b = msb[k] / 16;
        if (r >= 600 && g >= 600 && b >= 600) return 0;
        if (r >= 512 && g >= 512 && b < 384)  return 1;
        if (r >= 512 && g < 256)              return 2;
        if (r >= 512 && g < 512)              return 3;
        if (g > r && g >= b)                  return 4;
        return 5;
    endfunction

    function automatic logic [26:0] mface();
        logic [26:0] f;
        for (int k = 0; k < 9; k++) f[3*k +: 3] = 3'(mcode(k));
        return f;
    endfunction

    task automatic drive(input int fs, input int st, input pix_t p);
        @(posedge clk); #1;
        frame_start = (fs != 0); start = (st != 0); pix_valid = (p.v != 0);
        pix_x = 11'(p.x); pix_y = 11'(p.y);
        pix_r = 10'(p.r); pix_g = 10'(p.g); pix_b = 10'(p.b);
    endtask

    task automatic grid();
        for (int k = 0; k < 9; k++) begin
            mcx[k] = 100 + 40 * (k % 3);
            mcy[k] = 100 + 40 * (k / 3);
        end
    endtask

    task automatic begin_case();
        q.delete();
        close_x = mcx[0];
        close_y = mcy[0];
    endtask

    // drop >= 0 leaves that pixel out and makes it the discarded closing pixel instead.
    task automatic add_window(input int k, input int r, input int g, input int b,
                              input int noise, input int gaps, input int drop);
        for (int i = 0; i < 16; i++) begin
            int x, y;
            x = mcx[k] - 2 + i % 4;
            y = mcy[k] - 2 + i / 4;
            if (x < 0 || y < 0) continue;
            if (i == drop) begin close_x = x; close_y = y; continue; end
            q.push_back(mk(1, x, y, clip(r + $urandom_range(0, noise)),
                           clip(g + $urandom_range(0, noise)), clip(b + $urandom_range(0, noise))));
            if (gaps != 0 && $urandom_range(0, 3) == 0)
                q.push_back(mk(0, x, y, 1023, 1023, 1023));
        end
        if (mcx[k] + 2 < 2048) q.push_back(mk(1, mcx[k] + 2, mcy[k], 1023, 1023, 1023));
        if (mcy[k] - 3 >= 0)   q.push_back(mk(1, mcx[k], mcy[k] - 3, 1023, 1023, 1023));
    endtask

    task automatic start_scan();
        for (int k = 0; k < 9; k++) begin
            bx[k] = 11'(mcx[k]); by[k] = 11'(mcy[k]);
            msr[k] = 0; msg[k] = 0; msb[k] = 0; mcnt[k] = 0;
        end
        drive(0, 1, mk(1, mcx[0], mcy[0], 1023, 1023, 1023));
        drive(0, 0, mk(1, mcx[0], mcy[0], 1023, 1023, 1023));
        @(negedge clk);
        check("busy_after_start", busy, 1);
        drive(0, 0, mk(1, mcx[0], mcy[0], 1023, 1023, 1023));
    endtask

    task automatic send_frame(input int inject, input int stop_at);
        for (int i = 0; i < q.size() && i != stop_at; i++) begin
            if (i == inject)
                for (int k = 0; k < 9; k++) begin bx[k] = 11'(mcx[k] + 300); by[k] = 11'(mcy[k] + 7); end
            drive(i == 0, i == inject, q[i]);
            if (q[i].v != 0) model_pix(q[i]);
        end
    endtask

    task automatic finish_scan(input string name);
        int lat;
        logic [26:0] exp;
        exp = mface();
        drive(1, 0, mk(1, close_x, close_y, 1023, 0, 0));
        @(negedge clk);
        check({name, "_done_at_T"}, done, 0);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, mk(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        check({name, "_latency"}, lat, 10);
        check({name, "_face"}, face_colors, exp);
        check({name, "_busy_at_done"}, busy, 1);
        drive(0, 0, mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [26:0] e;
        tbl[0]  = '{900, 900, 900, 0};  tbl[1]  = '{512, 511, 100, 3};
        tbl[2]  = '{512, 512, 383, 1};  tbl[3]  = '{599, 900, 900, 4};
        tbl[4]  = '{800, 100, 100, 2};  tbl[5]  = '{100, 700, 200, 4};
        tbl[6]  = '{100, 100, 800, 5};  tbl[7]  = '{600, 600, 600, 0};
        tbl[8]  = '{512, 255, 0, 2};    tbl[9]  = '{512, 512, 384, 5};
        tbl[10] = '{300, 300, 300, 5};  tbl[11] = '{512, 256, 900, 3};

        reset = 1; start = 0; frame_start = 0; pix_valid = 0;
        pix_x = 0; pix_y = 0; pix_r = 0; pix_g = 0; pix_b = 0;
        for (int k = 0; k < 9; k++) begin bx[k] = 0; by[k] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_face", face_colors, 27'h7FFFFFF);
        #1 reset = 0;

        // all white
        grid(); begin_case();
        for (int k = 0; k < 9; k++) add_window(k, 900, 900, 900, 0, 0, -1);
        start_scan(); send_frame(-1, -1); finish_scan("white");
        check("white_const", face_colors, 27'h0);

        // red centre, green corner, blue rest; window 2 revisited to exercise saturation
        grid(); begin_case();
        for (int k = 0; k < 9; k++)
            if (k == 4)      add_window(k, 800, 100, 100, 0, 0, -1);
            else if (k == 0) add_window(k, 100, 700, 200, 0, 0, -1);
            else             add_window(k, 100, 100, 800, 0, 0, -1);
        add_window(1, 0, 0, 0, 0, 0, -1);
        start_scan(); send_frame(-1, -1); finish_scan("mixed");
        e = '0;
        for (int k = 0; k < 9; k++) e[3*k +: 3] = 3'd5;
        e[2:0] = 3'd4; e[14:12] = 3'd2;
        check("mixed_const", face_colors, e);

        // table-driven boundary colours
        for (int s = 0; s < 2; s++) begin
            grid(); begin_case();
            for (int k = 0; k < 9; k++) begin
                int t;
                t = (s * 9 + k) % 12;
                add_window(k, tbl[t].r, tbl[t].g, tbl[t].b, 0, s, -1);
            end
            start_scan(); send_frame(-1, -1); finish_scan("table");
            for (int k = 0; k < 9; k++)
                check($sformatf("table_s%0d_blk%0d", s, k + 1), face_colors[3*k +: 3],
                      tbl[(s * 9 + k) % 12].code);
        end

        // clipped block 1; block 9 short one pixel, offered only on the closing frame_start
        grid(); mcx[0] = 1; mcy[0] = 1; begin_case();
        for (int k = 0; k < 8; k++) add_window(k, tbl[k].r, tbl[k].g, tbl[k].b, 0, 0, -1);
        add_window(8, 800, 100, 100, 0, 0, 15);
        start_scan(); send_frame(-1, -1); finish_scan("clip");
        check("clip_blk1", face_colors[2:0], 7);
        check("discard_blk9", face_colors[26:24], 7);
        check("clip_blk2", face_colors[5:3], tbl[1].code);

        // start during capture with other centres is ignored
        grid(); begin_case();
        for (int k = 0; k < 9; k++) add_window(k, $urandom_range(0, 1023), $urandom_range(0, 1023),
                                               $urandom_range(0, 1023), 8, 1, -1);
        start_scan(); send_frame(q.size() / 2, -1); finish_scan("start_in_capture");

        // reset mid-capture, then a fresh scan
        grid(); begin_case();
        for (int k = 0; k < 9; k++) add_window(k, 900, 900, 900, 0, 0, -1);
        start_scan(); send_frame(-1, q.size() / 2);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_face", face_colors, 27'h7FFFFFF);
        start_scan(); send_frame(-1, -1); finish_scan("after_reset");

        // randomized scans, possibly overlapping windows, opening pulse sometimes without a pixel
        for (int round = 0; round < 6; round++) begin
            for (int k = 0; k < 9; k++) begin
                mcx[k] = $urandom_range(0, 300);
                mcy[k] = $urandom_range(0, 300);
            end
            begin_case();
            if (round % 2 == 0) q.push_back(mk(0, mcx[0], mcy[0], 1023, 1023, 1023));
            for (int k = 0; k < 9; k++) begin
                add_window(k, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                           $urandom_range(0, 40), 1, ($urandom_range(0, 5) == 0) ? 0 : -1);
                if ($urandom_range(0, 3) == 0)
                    add_window(k, $urandom_range(0, 1023), 0, 0, 0, 0, -1);
            end
            start_scan(); send_frame(-1, -1); finish_scan($sformatf("rand%0d", round));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/face_color_sampler.md
# face_color_sampler

Downstream consumer of the nine block-centre coordinates produced by the cube-centre stage. On a start pulse it latches the centres and waits for the next frame of the DE2 CCD pixel stream. Over that one frame it accumulates RGB in a 4×4 window around each centre, then classifies each window average into one of six sticker colours. It presents the 9-sticker face code to the solver front end with a done pulse.

## Interface
- No parameters; window is fixed at 4×4 and pixel channels at 10 bits.
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; typically driven from gotCenters
- BlockkX, BlockkY (k=1..9)  in  11 each  block-centre coordinates; sampled only when start is accepted
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- pix_valid  in  1  pix_x/pix_y/pix_r/pix_g/pix_b are valid this cycle
- pix_x, pix_y  in  11 each  current pixel coordinate
- pix_r, pix_g, pix_b  in  10 each  current pixel colour
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; face_colors is final
- face_colors  out  27  block k code at bits [3k-1:3k-3]; codes: 0 white, 1 yellow, 2 red, 3 orange, 4 green, 5 blue, 7 unknown

## Operation
- **State machine:** IDLE, WAIT_FRAME, CAPTURE, CLASSIFY, DONE.
- **IDLE:**
  - start=1 latches all 18 coordinates.
  - Clears the nine accumulator sets (R, G, B sums of 14 bits each; pixel count of 5 bits).
  - Moves to WAIT_FRAME.
- **start while busy:** ignored. Latched coordinates are not disturbed.
- **WAIT_FRAME:**
  - On frame_start, moves to CAPTURE.
  - The pixel on the frame_start cycle is accumulated if pix_valid=1.
- **CAPTURE:**
  - Every pix_valid pixel is tested against all nine windows in parallel.
  - Window k is BlockkX-2 ≤ pix_x ≤ BlockkX+1 and BlockkY-2 ≤ pix_y ≤ BlockkY+1.
  - Compares are 12-bit signed, so a centre below 2 clips the window rather than wrapping.
  - On a hit, the pixel's R/G/B are added to window k's sums and its count is incremented. Count saturates at 16.
  - Overlapping windows (N<12) may both accumulate the same pixel. This is allowed; no special handling.
- **End of capture:**
  - The next frame_start moves to CLASSIFY with block index 0.
  - The pixel on that cycle is discarded.
- **CLASSIFY:**
  - One block per cycle, k=1..9. Average = sum>>4 per channel.
  - count≠16 gives code 7.
  - Otherwise first match wins:
    - white: r,g,b all ≥600
    - yellow: r≥512, g≥512, b<384
    - red: r≥512, g<256
    - orange: r≥512, 256≤g<512
    - green: g>r and g≥b
    - blue: all other cases
  - The code is written into face_colors the same cycle.
  - After block 9, moves to DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **Reset mid-operation:** abandons the scan, returns to IDLE, and restores all outputs to reset values.

## Timing
- **Reset values:**
  - busy=0, done=0
  - face_colors=27'h7FFFFFF (all unknown)
  - accumulators 0
- **busy:** rises the cycle after start is accepted and falls the cycle after done.
- **Capture:** spans exactly one frame, from a frame_start through the next frame_start, exclusive of that second pulse.
- **Latency:**
  - Closing frame_start at cycle T puts block 1's code on face_colors at T+1 and block 9's at T+9.
  - done=1 at T+10.
  - start is accepted again from T+11.
- **face_colors between scans:**
  - Updates block by block during CLASSIFY and holds the final value until the next CLASSIFY.
  - Partial values are visible before done; consumers must qualify on done.
- **Accumulator width:** 16×1023 = 16368 fits 14 bits; no overflow is possible because count saturation blocks a 17th add.
- **frame_start:**
  - frame_start in IDLE, CLASSIFY or DONE is ignored.
  - frame_start with pix_valid=0 still counts as the frame boundary.

## Test plan
- All centres at (100+40i, 100+40j); frame with every window pixel = (900,900,900) -> face_colors=0 (all white), done at closing frame_start+10.
- Same centres; window 5 = (800,100,100), window 1 = (100,700,200), others (100,100,800) -> block5=2, block1=4, rest=5.
- Block1X=1, Block1Y=1 -> window clipped to 9 pixels -> block1=7; other blocks classify normally.
- start pulsed during CAPTURE with different centres -> ignored; result matches the original centres.
- Reset asserted mid-CAPTURE -> next cycle busy=0, face_colors=27'h7FFFFFF; a fresh start completes normally.
- Boundary colours (512,511,100) -> orange (3); (512,512,383) -> yellow (1); (599,900,900) -> green (4).
